fifo_write_ctrl: RTL and testbench



---
 rtl/fifo_write_ctrl_pkg.sv | 24 ++
 rtl/fifo_write_ctrl_wptr_full.sv | 32 +++
 rtl/fifo_write_ctrl.sv | 81 ++++++++
 tb/tb_fifo_write_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared definitions for the handshake FIFO controllers: state encoding,
// default widths and the pointer comparisons used by both write and read sides.
package fifo_write_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HS    = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Pointers carry a wrap bit at index addr_w; full means same slot, opposite pass.
  function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b,
                                    input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (a[addr_w] != b[addr_w]) && (((a ^ b) & mask) == 32'd0);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_wptr_full.sv
// Write pointer register plus the full flag and fill level derived from it
// and the read side's pointer.
module fifo_wptr_full
  import fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic [ADDR_W:0]   i_rd_ptr,
  output logic [ADDR_W:0]   o_wr_ptr,
  output logic              o_full,
  output logic [ADDR_W:0]   o_level
);

  logic [ADDR_W:0] r_wr_ptr;

  // Natural wrap of the ADDR_W+1 bit counter toggles the wrap bit each pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (i_inc) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_full   = ptr_full(32'(r_wr_ptr), 32'(i_rd_ptr), ADDR_W);
  assign o_level  = r_wr_ptr - i_rd_ptr;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Producer-side controller: one word per write_en/ack handshake, held in a
// register and pushed to storage with a single-cycle write strobe.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic              ack,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wr_ptr
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              w_load;
  logic              w_full;
  logic [DATA_W-1:0] r_hold;

  // full only gates the start of a transaction; a word in flight always completes.
  always_comb begin
    w_next_state = ST_IDLE;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (write_en && !w_full) begin
          w_next_state = ST_HS;
          w_load       = 1'b1;
        end
      end
      ST_HS:    w_next_state = write_en ? ST_HS : ST_WRITE;
      ST_WRITE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_load) begin
      r_hold <= data_in;
    end
  end

  fifo_wptr_full #(
    .ADDR_W (ADDR_W)
  ) u_wptr_full (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (mem_we),
    .i_rd_ptr (rd_ptr),
    .o_wr_ptr (wr_ptr),
    .o_full   (w_full),
    .o_level  (level)
  );

  // Moore outputs; the illegal encoding decodes to neither ack nor strobe.
  assign ack       = (r_state == ST_HS);
  assign mem_we    = (r_state == ST_WRITE);
  assign mem_waddr = wr_ptr[ADDR_W-1:0];
  assign mem_wdata = r_hold;
  assign full      = w_full;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with a transaction-level reference model.
module tb_fifo_write_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int PMOD   = 1 << (ADDR_W + 1);
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W:0]   rd_ptr;
  logic              ack;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   wr_ptr;

  fifo_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .data_in   (data_in),
    .rd_ptr    (rd_ptr),
    .ack       (ack),
    .full      (full),
    .level     (level),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wr_ptr    (wr_ptr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt  = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int                log_cyc[$];

  // Reference model: handshake open, word due, held word, total words written.
  bit              m_open = 1'b0;
  bit              m_due  = 1'b0;
  logic [DATA_W-1:0] m_hold = '0;
  int              m_words = 0;

  function automatic int m_level();
    int d;
    d = m_words - int'(rd_ptr);
    return ((d % PMOD) + PMOD) % PMOD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open  <= 1'b0;
      m_due   <= 1'b0;
      m_hold  <= '0;
      m_words <= 0;
    end else if (m_due) begin
      m_due   <= 1'b0;
      m_words <= m_words + 1;
    end else if (m_open) begin
      if (!write_en) begin
        m_open <= 1'b0;
        m_due  <= 1'b1;
      end
    end else if (write_en && (m_level() != DEPTH)) begin
      m_open <= 1'b1;
      m_hold <= data_in;
    end
  end

  always @(negedge clk) begin
    chk("ack", 32'(ack), 32'(m_open));
    chk("mem_we", 32'(mem_we), 32'(m_due));
    chk("wr_ptr", 32'(wr_ptr), 32'(m_words % PMOD));
    chk("level", 32'(level), 32'(m_level()));
    chk("full", 32'(full), 32'(m_level() == DEPTH));
    if (m_due) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_words % DEPTH));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_hold));
    end
    if (mem_we) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
    if (ack) ack_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack();
    int k = 0;
    while (!ack && k < 40) begin
      tick(1);
      k++;
    end
    chk("ack_wait", 32'(ack), 32'd1);
  endtask

  task automatic wait_we_done();
    int k = 0;
    while (!mem_we && k < 40) begin
      tick(1);
      k++;
    end
    chk("we_wait", 32'(mem_we), 32'd1);
    tick(1);
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d, input int hold);
    data_in  = d;
    write_en = 1'b1;
    wait_ack();
    tick(hold);
    write_en = 1'b0;
    wait_we_done();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; write_en = 1'b0; data_in = '0; rd_ptr = '0;
    tick(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b0;
    tick(1);

    // Single write held three cycles.
    ack_cnt = 0;
    data_in = 8'hA5; write_en = 1'b1;
    tick(3);
    write_en = 1'b0;
    tick(3);
    chk("t1_ack_cycles", 32'(ack_cnt), 32'd3);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd1);
    chk("t1_addr", 32'(log_addr[0]), 32'd0);
    chk("t1_data", 32'(log_data[0]), 32'hA5);
    chk("t1_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_full", 32'(full), 32'd0);

    // Fill to full from an empty FIFO.
    pulse_rst();
    n = log_addr.size();
    for (int i = 0; i < 8; i++) do_write(8'(8'h10 + i), 0);
    for (int i = 0; i < 8; i++) begin
      chk("fill_addr", 32'(log_addr[n+i]), 32'(i));
      chk("fill_data", 32'(log_data[n+i]), 32'(8'h10 + i));
    end
    chk("fill_wr_ptr", 32'(wr_ptr), 32'h8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);

    // Blocked while full, released by the read side.
    n = log_addr.size();
    ack_cnt = 0;
    data_in = 8'h55; write_en = 1'b1;
    tick(5);
    chk("blk_ack_cycles", 32'(ack_cnt), 32'd0);
    chk("blk_nwrites", 32'(log_addr.size()), 32'(n));
    rd_ptr = 4'd1;
    #1;
    chk("blk_full_drop", 32'(full), 32'd0);
    tick(1);
    chk("blk_ack_rise", 32'(ack), 32'd1);
    write_en = 1'b0;
    wait_we_done();
    chk("blk_addr", 32'(log_addr[log_addr.size()-1]), 32'd0);
    chk("blk_data", 32'(log_data[log_data.size()-1]), 32'h55);
    chk("blk_wr_ptr", 32'(wr_ptr), 32'h9);

    // data_in changes during HS are ignored.
    rd_ptr = 4'd5;
    data_in = 8'h3C; write_en = 1'b1;
    tick(1);
    data_in = 8'hFF;
    tick(1);
    write_en = 1'b0;
    wait_we_done();
    chk("stab_data", 32'(log_data[log_data.size()-1]), 32'h3C);
    chk("stab_addr", 32'(log_addr[log_addr.size()-1]), 32'd1);
    chk("stab_wr_ptr", 32'(wr_ptr), 32'd10);

    // Pointer wrap past 2**(ADDR_W+1)-1.
    rd_ptr = 4'd10;
    for (int i = 0; i < 7; i++) do_write(8'(8'h60 + i), 1);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("wrap_level", 32'(level), 32'd7);
    chk("wrap_full", 32'(full), 32'd0);
    chk("wrap_addr", 32'(log_addr[log_addr.size()-1]), 32'd0);

    // Reset in the middle of a handshake.
    rd_ptr = '0;
    pulse_rst();
    do_write(8'h21, 0);
    do_write(8'h22, 0);
    data_in = 8'h77; write_en = 1'b1;
    wait_ack();
    n = log_addr.size();
    rst = 1'b1;
    #1;
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("mrst_we", 32'(mem_we), 32'd0);
    write_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mrst_nwrites", 32'(log_addr.size()), 32'(n));
    do_write(8'h99, 1);
    chk("mrst_addr", 32'(log_addr[log_addr.size()-1]), 32'd0);
    chk("mrst_data", 32'(log_data[log_data.size()-1]), 32'h99);

    // One-cycle pulse, then re-raise during WRITE.
    n = log_addr.size();
    ack_cnt = 0;
    data_in = 8'h81; write_en = 1'b1;
    tick(1);
    write_en = 1'b0;
    tick(1);
    data_in = 8'h82; write_en = 1'b1;
    tick(2);
    chk("pulse_ack_cycles", 32'(ack_cnt), 32'd1);
    write_en = 1'b0;
    tick(2);
    chk("pulse_nwrites", 32'(log_addr.size()), 32'(n + 2));
    if (log_addr.size() >= n + 2) begin
      chk("pulse_addr0", 32'(log_addr[n]), 32'd1);
      chk("pulse_addr1", 32'(log_addr[n+1]), 32'd2);
      chk("pulse_data0", 32'(log_data[n]), 32'h81);
      chk("pulse_data1", 32'(log_data[n+1]), 32'h82);
      chk("pulse_spacing", 32'(log_cyc[n+1] - log_cyc[n]), 32'd3);
    end
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
